// File: rtl/padder_pkg.sv
// Shared types and constants for the pipelined-adder result buffer.
package padder_pkg;

   localparam int unsigned PADDER_LATENCY = 4;
   localparam int unsigned PADDER_DEPTH   = 8;
   localparam int unsigned PADDER_WIDTH   = 32;

   typedef struct packed {
      logic                    carry;
      logic [PADDER_WIDTH-1:0] sum;
   } padder_result_t;

   // Width needed to hold values 0..max_val.
   function automatic int unsigned count_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/padder_result_buffer_if.sv
// Issue/capture/delivery handshake between upstream, adder outputs, downstream and the buffer.
interface padder_result_buffer_if;
   import padder_pkg::*;

   logic                    in_issue;
   logic [PADDER_WIDTH-1:0] S;
   logic                    CO;
   logic                    issue_ok;
   logic                    out_valid;
   logic [PADDER_WIDTH-1:0] out_sum;
   logic                    out_carry;
   logic                    out_ready;
   logic                    err;

   modport master (
      output in_issue,
      output S,
      output CO,
      output out_ready,
      input  issue_ok,
      input  out_valid,
      input  out_sum,
      input  out_carry,
      input  err
   );

   modport slave (
      input  in_issue,
      input  S,
      input  CO,
      input  out_ready,
      output issue_ok,
      output out_valid,
      output out_sum,
      output out_carry,
      output err
   );

endinterface

// File: rtl/padder_result_fifo.sv
// Synchronous FIFO of adder results with first-word fall-through head and occupancy count.
module padder_result_fifo
   import padder_pkg::*;
#(
   parameter int unsigned DEPTH = PADDER_DEPTH
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  padder_result_t         data_i,
   input  logic                   pop_i,
   output padder_result_t         data_o,
   output logic                   empty_o,
   output logic                   overflow_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   padder_result_t  mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            full;
   logic            do_push;
   logic            do_pop;

   assign empty_o = (count_q == '0);
   assign full    = (count_q == CntW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
   assign do_push    = push_i && (!full || do_pop);
   assign overflow_o = push_i && full && !do_pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Stale storage is masked so the head reads zero whenever nothing is buffered.
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/padder_result_buffer.sv
// Credit-controlled result buffer behind a fixed-latency pipelined adder.
// Optional PADDER_RESULT_STATS_EN adds result_count/carry_count pop statistics.
module padder_result_buffer
   import padder_pkg::*;
#(
   parameter int unsigned LATENCY = PADDER_LATENCY,
   parameter int unsigned DEPTH   = PADDER_DEPTH
) (
   input logic                   Clock,
   input logic                   Reset,
   padder_result_buffer_if.slave bus
`ifdef PADDER_RESULT_STATS_EN
   ,
   output logic [31:0]           result_count,
   output logic [31:0]           carry_count
`endif
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam int unsigned SumW = count_width(LATENCY + DEPTH);

   logic [LATENCY-1:0] tag_q, tag_d;
   logic [SumW-1:0]    inflight;
   logic [SumW-1:0]    credit_used;
   logic [CntW-1:0]    occupancy;
   logic               capture;
   logic               pop;
   logic               overflow;
   logic               fifo_empty;
   logic               issue_ok;
   logic               err_q, err_d;
   padder_result_t     push_data;
   padder_result_t     head;

   // Tags keep marching even for illegal issues so their results are still captured.
   always_comb begin
      tag_d    = tag_q << 1;
      tag_d[0] = bus.in_issue;
   end

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
         inflight = inflight + SumW'(tag_q[i]);
      end
   end

   assign credit_used = inflight + SumW'(occupancy);
   assign issue_ok    = (credit_used < SumW'(DEPTH));

   assign capture   = tag_q[LATENCY-1];
   assign push_data = '{carry: bus.CO, sum: bus.S};
   assign pop       = !fifo_empty && bus.out_ready;

   padder_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i      (Clock),
      .rst_i      (Reset),
      .push_i     (capture),
      .data_i     (push_data),
      .pop_i      (pop),
      .data_o     (head),
      .empty_o    (fifo_empty),
      .overflow_o (overflow),
      .count_o    (occupancy)
   );

   assign err_d = err_q | (bus.in_issue & ~issue_ok) | overflow;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         tag_q <= '0;
         err_q <= 1'b0;
      end else begin
         tag_q <= tag_d;
         err_q <= err_d;
      end
   end

   assign bus.issue_ok  = issue_ok;
   assign bus.out_valid = !fifo_empty;
   assign bus.out_sum   = head.sum;
   assign bus.out_carry = head.carry;
   assign bus.err       = err_q;

`ifdef PADDER_RESULT_STATS_EN
   logic [31:0] result_count_q, result_count_d;
   logic [31:0] carry_count_q, carry_count_d;

   always_comb begin
      result_count_d = result_count_q;
      carry_count_d  = carry_count_q;
      if (pop) begin
         result_count_d = result_count_q + 32'd1;
         if (head.carry) begin
            carry_count_d = carry_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         result_count_q <= '0;
         carry_count_q  <= '0;
      end else begin
         result_count_q <= result_count_d;
         carry_count_q  <= carry_count_d;
      end
   end

   assign result_count = result_count_q;
   assign carry_count  = carry_count_q;
`endif

endmodule

// File: tb/tb_padder_result_buffer.sv
// Directed bench for padder_result_buffer: vector table plus hand-written corner sequences.
module tb_padder_result_buffer;

   localparam logic [31:0] J = 32'hBAD0_0000;

   typedef struct {
      logic        iss;
      logic [31:0] s;
      logic        co;
      logic        rdy;
      logic        e_valid;
      logic [31:0] e_sum;
      logic        e_carry;
      logic        e_ok;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   vec_t vecs [17];

`ifdef PADDER_RESULT_STATS_EN
   logic [31:0] result_count;
   logic [31:0] carry_count;
`endif

   padder_result_buffer_if bus ();

   padder_result_buffer dut (
      .Clock        (clk),
      .Reset        (rst),
      .bus          (bus)
`ifdef PADDER_RESULT_STATS_EN
      ,
      .result_count (result_count),
      .carry_count  (carry_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iss, input logic [31:0] s, input logic co, input logic rdy);
      bus.in_issue  = iss;
      bus.S         = s;
      bus.CO        = co;
      bus.out_ready = rdy;
   endtask

   // Reset with issue and ready asserted: reset must win over both.
   task automatic do_reset();
      drive(1'b1, J, 1'b1, 1'b1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic vec_t mk(input logic iss, input logic [31:0] s, input logic co,
                               input logic rdy, input logic ev, input logic [31:0] es,
                               input logic ec);
      vec_t v;
      v = '{iss, s, co, rdy, ev, es, ec, 1'b1};
      return v;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      drive(1'b0, J, 1'b1, 1'b0);

      // Single result, then four back-to-back issues drained at one per cycle.
      vecs[0]  = mk(1'b1, J,             1'b1, 1'b0, 1'b0, 32'h0,         1'b0);
      vecs[1]  = mk(1'b0, J,             1'b1, 1'b0, 1'b0, 32'h0,         1'b0);
      vecs[2]  = mk(1'b0, J,             1'b1, 1'b0, 1'b0, 32'h0,         1'b0);
      vecs[3]  = mk(1'b0, J,             1'b1, 1'b0, 1'b0, 32'h0,         1'b0);
      vecs[4]  = mk(1'b0, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0);
      vecs[5]  = mk(1'b0, J,             1'b1, 1'b1, 1'b1, 32'h0000_0005, 1'b0);
      vecs[6]  = mk(1'b0, J,             1'b1, 1'b1, 1'b0, 32'h0,         1'b0);
      vecs[7]  = mk(1'b1, J,             1'b1, 1'b1, 1'b0, 32'h0,         1'b0);
      vecs[8]  = mk(1'b1, J,             1'b1, 1'b1, 1'b0, 32'h0,         1'b0);
      vecs[9]  = mk(1'b1, J,             1'b1, 1'b1, 1'b0, 32'h0,         1'b0);
      vecs[10] = mk(1'b1, J,             1'b1, 1'b1, 1'b0, 32'h0,         1'b0);
      vecs[11] = mk(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0);
      vecs[12] = mk(1'b0, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
      vecs[13] = mk(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
      vecs[14] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
      vecs[15] = mk(1'b0, J,             1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
      vecs[16] = mk(1'b0, J,             1'b1, 1'b1, 1'b0, 32'h0,         1'b0);

      @(negedge clk);
      do_reset();
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_sum",   bus.out_sum,        32'd0);
      chk("rst_carry", 32'(bus.out_carry), 32'd0);
      chk("rst_ok",    32'(bus.issue_ok),  32'd1);
      chk("rst_err",   32'(bus.err),       32'd0);

      for (int i = 0; i < 17; i++) begin
         chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
         if (vecs[i].e_valid) begin
            chk($sformatf("tbl%0d_sum", i),   bus.out_sum,        vecs[i].e_sum);
            chk($sformatf("tbl%0d_carry", i), 32'(bus.out_carry), 32'(vecs[i].e_carry));
         end
         chk($sformatf("tbl%0d_ok", i),  32'(bus.issue_ok), 32'(vecs[i].e_ok));
         chk($sformatf("tbl%0d_err", i), 32'(bus.err),      32'd0);
         drive(vecs[i].iss, vecs[i].s, vecs[i].co, vecs[i].rdy);
         @(negedge clk);
      end

      // Fill to the credit limit with downstream stalled.
      do_reset();
      for (int c = 0; c < 12; c++) begin
         chk($sformatf("fill%0d_ok", c), 32'(bus.issue_ok), (c < 8) ? 32'd1 : 32'd0);
         chk($sformatf("fill%0d_err", c), 32'(bus.err), 32'd0);
         drive(c < 8, (c >= 4) ? 32'(100 + c - 4) : J, (c >= 4) ? 1'((c - 4) & 1) : 1'b1, 1'b0);
         @(negedge clk);
      end
      for (int c = 12; c < 14; c++) begin
         drive(1'b0, J, 1'b1, 1'b0);
         chk($sformatf("full%0d_ok", c),    32'(bus.issue_ok),  32'd0);
         chk($sformatf("full%0d_valid", c), 32'(bus.out_valid), 32'd1);
         chk($sformatf("full%0d_sum", c),   bus.out_sum,        32'd100);
         chk($sformatf("full%0d_err", c),   32'(bus.err),       32'd0);
         @(negedge clk);
      end
      // Illegal issue while out of credit: flagged, yet still tracked.
      chk("illegal_ok", 32'(bus.issue_ok), 32'd0);
      drive(1'b1, J, 1'b1, 1'b0);
      @(negedge clk);
      for (int c = 15; c < 18; c++) begin
         drive(1'b0, J, 1'b1, 1'b0);
         chk($sformatf("hold%0d_err", c), 32'(bus.err),  32'd1);
         chk($sformatf("hold%0d_sum", c), bus.out_sum,   32'd100);
         @(negedge clk);
      end
      // Capture into a full FIFO with a simultaneous pop.
      chk("pp_valid", 32'(bus.out_valid), 32'd1);
      chk("pp_sum",   bus.out_sum,        32'd100);
      drive(1'b0, 32'd200, 1'b1, 1'b1);
      @(negedge clk);
      drive(1'b0, J, 1'b1, 1'b0);
      chk("pp_after_sum",   bus.out_sum,        32'd101);
      chk("pp_after_carry", 32'(bus.out_carry), 32'd1);
      chk("pp_after_ok",    32'(bus.issue_ok),  32'd0);
      chk("pp_after_err",   32'(bus.err),       32'd1);
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, J, 1'b1, 1'b1);
         chk($sformatf("drain%0d_valid", k), 32'(bus.out_valid), 32'd1);
         chk($sformatf("drain%0d_sum", k),   bus.out_sum, (k < 7) ? 32'(101 + k) : 32'd200);
         chk($sformatf("drain%0d_carry", k), 32'(bus.out_carry),
             (k < 7) ? 32'((k + 1) & 1) : 32'd1);
         @(negedge clk);
      end
      drive(1'b0, J, 1'b1, 1'b0);
      chk("drained_valid", 32'(bus.out_valid), 32'd0);
      chk("drained_ok",    32'(bus.issue_ok),  32'd1);
      chk("drained_err",   32'(bus.err),       32'd1);
      @(negedge clk);
      chk("sticky_err", 32'(bus.err), 32'd1);
      do_reset();
      chk("err_cleared", 32'(bus.err), 32'd0);

      // Reset with three results in flight and two buffered.
      for (int c = 0; c < 7; c++) begin
         if (c == 6) begin
            chk("mid_valid", 32'(bus.out_valid), 32'd1);
            chk("mid_sum",   bus.out_sum,        32'd300);
         end
         drive(c == 0 || c == 1 || c >= 4, (c == 4) ? 32'd300 : ((c == 5) ? 32'd301 : J),
               1'b0, 1'b0);
         @(negedge clk);
      end
      chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      drive(1'b1, J, 1'b1, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, J, 1'b1, 1'b0);
      chk("post_rst_ok",  32'(bus.issue_ok), 32'd1);
      chk("post_rst_sum", bus.out_sum,       32'd0);
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("post_rst%0d_valid", c), 32'(bus.out_valid), 32'd0);
         chk($sformatf("post_rst%0d_err", c),   32'(bus.err),       32'd0);
         @(negedge clk);
      end

`ifdef PADDER_RESULT_STATS_EN
      do_reset();
      chk("stats_rst_results", result_count, 32'd0);
      chk("stats_rst_carries", carry_count,  32'd0);
      for (int c = 0; c < 11; c++) begin
         drive(c < 3, (c >= 4 && c < 7) ? 32'(c) : J, (c == 5) ? 1'b0 : 1'b1, 1'b1);
         @(negedge clk);
      end
      chk("stats_results", result_count, 32'd3);
      chk("stats_carries", carry_count,  32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
